// File: rtl/rggen_apb_cmd_master.sv
// rggen_apb_cmd_master
//   Turns a valid/ready command stream into single APB3/APB4 transfers and
//   returns read data and error status on a valid/ready response stream.
//   One transfer is in flight at a time: IDLE -> SETUP -> ACCESS -> RESP.
//
//   Optional build macro: RGGEN_APB_CMD_MASTER_TIMEOUT_EN
//     When defined, an ACCESS phase that sees no pready for TIMEOUT_CYCLES
//     cycles is abandoned and answered with resp_error=1, read data 0.
//     When undefined, ACCESS waits for pready indefinitely.
//
//   Handshakes: a command moves when i_cmd_valid & o_cmd_ready are both 1 on
//   a rising clock edge; a response moves when o_resp_valid & i_resp_ready
//   are both 1 on a rising clock edge. Once raised, o_resp_valid and its data
//   hold until the response moves. o_cmd_ready never depends on i_cmd_valid.
//
//   o_debug_state exposes the FSM: 0=IDLE, 1=SETUP, 2=ACCESS, 3=RESP.
module rggen_apb_cmd_master #(
  parameter int ADDRESS_WIDTH  = 7,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_resp_valid,
  input  logic                     i_resp_ready,
  output logic [BUS_WIDTH-1:0]     o_resp_read_data,
  output logic                     o_resp_error,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [2:0]               o_pprot,
  output logic                     o_pwrite,
  output logic [BUS_WIDTH-1:0]     o_pwdata,
  output logic [BUS_WIDTH/8-1:0]   o_pstrb,
  input  logic                     i_pready,
  input  logic [BUS_WIDTH-1:0]     i_prdata,
  input  logic                     i_pslverr,
  output logic [1:0]               o_debug_state
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic cmd_accept;
  logic resp_handshake;
  logic access_done;
  logic access_timeout;

  // A new command can be taken when nothing is in flight, or when the
  // pending response is being consumed in this very cycle.
  assign o_cmd_ready    = (state == IDLE) || ((state == RESP) && i_resp_ready);
  assign cmd_accept     = i_cmd_valid && o_cmd_ready;
  assign resp_handshake = (state == RESP) && i_resp_ready;
  // pready (and therefore pslverr) only counts while psel&penable are high,
  // which is exactly the ACCESS state.
  assign access_done    = (state == ACCESS) && i_pready;

  assign o_pprot        = 3'b000;
  assign o_debug_state  = state;

`ifdef RGGEN_APB_CMD_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timeout_count;

  // Expiry fires on the last permitted ACCESS cycle without pready; a
  // pready arriving on that same cycle still completes normally.
  assign access_timeout = (state == ACCESS) && !i_pready &&
                          (timeout_count == TIMEOUT_LAST);

  // Count ACCESS cycles without pready; cleared while in SETUP so each
  // ACCESS phase starts from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timeout_count <= '0;
    end else if (state == SETUP) begin
      timeout_count <= '0;
    end else if ((state == ACCESS) && !i_pready && !access_timeout) begin
      timeout_count <= timeout_count + 16'd1;
    end
  end
`else
  // No timeout path in this build; constant 0 for any legal TIMEOUT_CYCLES.
  assign access_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_accept) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (access_done || access_timeout) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_handshake) begin
          state_next = cmd_accept ? SETUP : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // APB request side: load the command on accept, raise penable after the
  // single SETUP cycle, and release the bus when ACCESS ends.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_psel    <= 1'b0;
      o_penable <= 1'b0;
      o_paddr   <= '0;
      o_pwrite  <= 1'b0;
      o_pwdata  <= '0;
      o_pstrb   <= '0;
    end else if (cmd_accept) begin
      o_psel    <= 1'b1;
      o_penable <= 1'b0;
      o_paddr   <= i_cmd_address;
      o_pwrite  <= i_cmd_write;
      o_pwdata  <= i_cmd_write_data;
      o_pstrb   <= i_cmd_write ? i_cmd_strobe : {STRB_WIDTH{1'b0}};
    end else if (state == SETUP) begin
      o_penable <= 1'b1;
    end else if (access_done || access_timeout) begin
      o_psel    <= 1'b0;
      o_penable <= 1'b0;
    end
  end

  // Response side: capture the slave's answer (or a timeout) as ACCESS ends
  // and hold it until the consumer takes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_resp_valid     <= 1'b0;
      o_resp_read_data <= '0;
      o_resp_error     <= 1'b0;
    end else if (access_done) begin
      o_resp_valid     <= 1'b1;
      o_resp_read_data <= o_pwrite ? {BUS_WIDTH{1'b0}} : i_prdata;
      o_resp_error     <= i_pslverr;
    end else if (access_timeout) begin
      o_resp_valid     <= 1'b1;
      o_resp_read_data <= '0;
      o_resp_error     <= 1'b1;
    end else if (resp_handshake) begin
      o_resp_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rggen_apb_cmd_master.sv
// tb_rggen_apb_cmd_master
//   Directed bench for rggen_apb_cmd_master. A transaction-level model tracks
//   each accepted command by its age in cycles and queues the expected
//   responses; one compare process checks every DUT output against it on
//   each falling edge. Directed steps add hand-computed literal checks.
module tb_rggen_apb_cmd_master;

  localparam int AW = 7;
  localparam int BW = 32;
  localparam int SW = BW / 8;
  localparam int TO = 4;
`ifdef RGGEN_APB_CMD_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int edges = 0;
  initial forever begin
    @(posedge clk);
    edges++;
  end

  // ---------------- DUT ----------------
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [BW-1:0] cmd_write_data = '0;
  logic [SW-1:0] cmd_strobe = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [BW-1:0] resp_read_data;
  logic          resp_error;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic [BW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready = 1'b0;
  logic [BW-1:0] prdata = '0;
  logic          pslverr = 1'b0;
  logic [1:0]    debug_state;

  rggen_apb_cmd_master #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_write     (cmd_write),
    .i_cmd_address   (cmd_address),
    .i_cmd_write_data(cmd_write_data),
    .i_cmd_strobe    (cmd_strobe),
    .o_resp_valid    (resp_valid),
    .i_resp_ready    (resp_ready),
    .o_resp_read_data(resp_read_data),
    .o_resp_error    (resp_error),
    .o_psel          (psel),
    .o_penable       (penable),
    .o_paddr         (paddr),
    .o_pprot         (pprot),
    .o_pwrite        (pwrite),
    .o_pwdata        (pwdata),
    .o_pstrb         (pstrb),
    .i_pready        (pready),
    .i_prdata        (prdata),
    .i_pslverr       (pslverr),
    .o_debug_state   (debug_state)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- APB slave ----------------
  // Raises pready after slave_wait ACCESS cycles; slave_hang never answers.
  int          slave_wait = 0;
  bit          slave_hang = 1'b0;
  logic [BW-1:0] slave_rdata = '0;
  bit          slave_err = 1'b0;
  int          wait_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (psel && penable) begin
      pready = !slave_hang && (wait_cnt >= slave_wait);
      wait_cnt++;
    end else begin
      pready = 1'b0;
      wait_cnt = 0;
    end
    prdata  = slave_rdata;
    pslverr = slave_err;
  end

  // ---------------- model + scoreboard ----------------
  // m_busy: a command is on the bus; m_age: cycles since it was accepted
  // (0 = setup cycle, >=1 = access cycles). exp_q holds {error, read_data}.
  logic [BW:0]   exp_q[$];
  bit            m_busy = 1'b0;
  int            m_age = 0;
  logic          m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [BW-1:0] m_data = '0;
  logic [SW-1:0] m_strb = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0;
      m_age  = 0;
      exp_q.delete();
    end else begin
      bit ready_now;
      bit accept;
      ready_now = (!m_busy && exp_q.size() == 0) || (exp_q.size() > 0 && resp_ready);
      accept    = cmd_valid && ready_now;
      if (exp_q.size() > 0 && resp_ready) void'(exp_q.pop_front());
      if (m_busy) begin
        if (m_age >= 1 && pready) begin
          exp_q.push_back({pslverr, m_write ? {BW{1'b0}} : prdata});
          m_busy = 1'b0;
        end else if (TO_EN && m_age == TO) begin
          exp_q.push_back({1'b1, {BW{1'b0}}});
          m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end
      if (accept) begin
        m_busy  = 1'b1;
        m_age   = 0;
        m_write = cmd_write;
        m_addr  = cmd_address;
        m_data  = cmd_write_data;
        m_strb  = cmd_write ? cmd_strobe : '0;
      end
    end
  end

  // One compare process: every output, every cycle out of reset.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      bit  rv;
      logic [1:0] st;
      rv = (exp_q.size() > 0);
      st = m_busy ? ((m_age == 0) ? 2'd1 : 2'd2) : (rv ? 2'd3 : 2'd0);
      chk("cmd_ready", cmd_ready, (!m_busy && !rv) || (rv && resp_ready));
      chk("psel", psel, m_busy);
      chk("penable", penable, m_busy && m_age >= 1);
      chk("resp_valid", resp_valid, rv);
      chk("pprot", pprot, 3'b000);
      chk("state", debug_state, st);
      if (m_busy) begin
        chk("paddr", paddr, m_addr);
        chk("pwrite", pwrite, m_write);
        chk("pwdata", pwdata, m_data);
        chk("pstrb", pstrb, m_strb);
      end
      if (rv) begin
        chk("resp_read_data", resp_read_data, exp_q[0][BW-1:0]);
        chk("resp_error", resp_error, exp_q[0][BW]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d,
                          input logic [SW-1:0] s, output int acc_e);
    bit got;
    cmd_valid      = 1'b1;
    cmd_write      = w;
    cmd_address    = a;
    cmd_write_data = d;
    cmd_strobe     = s;
    acc_e = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      got = cmd_ready;
      @(posedge clk);
      #1;
      if (got) begin
        acc_e = edges;
        break;
      end
    end
    cmd_valid = 1'b0;
    if (acc_e < 0) fail_now("cmd_accept_wait");
  endtask

  // Latency counts the accept cycle as cycle 0.
  task automatic wait_resp(input int acc_e, output int lat, output logic [BW-1:0] d,
                           output logic e);
    lat = -1;
    d   = '0;
    e   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = edges - acc_e + 1;
        d   = resp_read_data;
        e   = resp_error;
        break;
      end
    end
    if (lat < 0) fail_now("resp_wait");
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc_a, acc_b, lat, cnt;
    logic [BW-1:0] d;
    logic e;
    bit found;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_pwdata", pwdata, 32'h0);
    #1 rst_n = 1'b1;

    // 1: write, immediate pready
    slave_wait = 0;
    send_cmd(1'b1, 7'h00, 32'h0000_00A5, 4'hF, acc_a);
    chk("t1_pwdata", pwdata, 32'h0000_00A5);
    chk("t1_pstrb", pstrb, 4'hF);
    chk("t1_setup", {psel, penable}, 2'b10);
    wait_resp(acc_a, lat, d, e);
    chk("t1_latency", lat, 3);
    chk("t1_data", d, 32'h0);
    chk("t1_err", e, 1'b0);

    // 2: read with two wait states
    slave_wait  = 2;
    slave_rdata = 32'h0000_005A;
    send_cmd(1'b0, 7'h04, 32'hDEAD_BEEF, 4'hF, acc_a);
    chk("t2_pstrb", pstrb, 4'h0);
    wait_resp(acc_a, lat, d, e);
    chk("t2_latency", lat, 5);
    chk("t2_data", d, 32'h0000_005A);
    chk("t2_err", e, 1'b0);

    // 3: read with slave error, then a clean write
    slave_wait  = 0;
    slave_rdata = 32'h0000_1234;
    slave_err   = 1'b1;
    send_cmd(1'b0, 7'h7C, 32'h0, 4'h3, acc_a);
    wait_resp(acc_a, lat, d, e);
    chk("t3_err", e, 1'b1);
    chk("t3_data", d, 32'h0000_1234);
    slave_err = 1'b0;
    send_cmd(1'b1, 7'h10, 32'h0000_55AA, 4'h5, acc_a);
    wait_resp(acc_a, lat, d, e);
    chk("t3_next_err", e, 1'b0);
    chk("t3_next_data", d, 32'h0);

    // 4: response stalled with a second command pending
    resp_ready = 1'b0;
    send_cmd(1'b1, 7'h20, 32'h0000_0011, 4'hF, acc_a);
    fork
      send_cmd(1'b0, 7'h24, 32'h0, 4'hF, acc_b);
      begin
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (resp_valid) begin
            found = 1'b1;
            break;
          end
        end
        if (!found) fail_now("t4_resp_wait");
        for (int i = 0; i < 4; i++) begin
          if (i > 0) @(negedge clk);
          chk("t4_stall_cmd_ready", cmd_ready, 1'b0);
          chk("t4_stall_psel", psel, 1'b0);
          chk("t4_stall_resp_valid", resp_valid, 1'b1);
          @(posedge clk);
          #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t4_ready_rise", cmd_ready, 1'b1);
        @(negedge clk);
        chk("t4_setup_next", {psel, penable, resp_valid}, 3'b100);
      end
    join
    wait_resp(acc_b, lat, d, e);
    chk("t4_b_latency", lat, 3);

    // 5: reset in the middle of a write's ACCESS phase
    slave_wait = 5;
    send_cmd(1'b1, 7'h30, 32'h0000_7777, 4'hF, acc_a);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (psel && penable) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("t5_access_wait");
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_psel", psel, 1'b0);
    chk("t5_async_penable", penable, 1'b0);
    chk("t5_async_resp_valid", resp_valid, 1'b0);
    chk("t5_async_paddr", paddr, 7'h00);
    slave_wait = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_post_cmd_ready", cmd_ready, 1'b1);
    chk("t5_post_state", debug_state, 2'd0);
    repeat (3) @(negedge clk);
    chk("t5_no_resp", resp_valid, 1'b0);
    slave_rdata = 32'hCAFE_F00D;
    send_cmd(1'b0, 7'h08, 32'h0, 4'hF, acc_a);
    wait_resp(acc_a, lat, d, e);
    chk("t5_after_data", d, 32'hCAFE_F00D);

    // 6: slave never answers
    slave_hang  = 1'b1;
    slave_rdata = 32'h1111_2222;
    send_cmd(1'b0, 7'h0C, 32'h0, 4'hF, acc_a);
    if (TO_EN) begin
      cnt = 0;
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (psel && penable) cnt++;
        else if (!psel) begin
          found = 1'b1;
          chk("t6_resp_valid", resp_valid, 1'b1);
          chk("t6_err", resp_error, 1'b1);
          chk("t6_data", resp_read_data, 32'h0);
          break;
        end
      end
      if (!found) fail_now("t6_timeout_wait");
      chk("t6_access_cycles", cnt, TO);
      @(posedge clk);
      #1;
    end else begin
      repeat (100) @(negedge clk);
      chk("t6_still_psel", psel, 1'b1);
      chk("t6_still_penable", penable, 1'b1);
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
    end
    slave_hang = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
